spart_fifo: RTL and testbench

//  Next-generation SPART: a buffered UART bridging the processor bus (iocs/iorw/ioaddr/databus) to a serial line.

---
 rtl/spart_fifo_if.sv | 24 ++
 rtl/spart_fifo.sv | 256 +++++++++++++++++++++++++
 tb/tb_spart_fifo.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/spart_fifo_if.sv
// spart_fifo_if
//   Processor-bus and serial-line signals of the buffered SPART.
//   The bidirectional databus is not carried here. It stays a plain
//   inout net on the module so tristate resolution remains at the top level.
//   iocs    chip select
//   iorw    1 = read, 0 = write
//   ioaddr  register address
//   rda     RX FIFO not empty
//   tbr     TX FIFO not full
//   txd     serial out, idle high
//   rxd     serial in, asynchronous
// Modports: master = bus/line driver side, slave = SPART side.
interface spart_fifo_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;
    logic       txd;
    logic       rxd;

    modport master (output iocs, iorw, ioaddr, rxd, input rda, tbr, txd);
    modport slave  (input iocs, iorw, ioaddr, rxd, output rda, tbr, txd);
endinterface

// File: rtl/spart_fifo.sv
// spart_fifo
//   Buffered UART that bridges the processor bus to a serial line. It has
//   TX and RX FIFOs, optional parity, 16x-style oversampled receive and
//   sticky error flags. The register map is unchanged from the original SPART:
//     00 data (write = push TX, read = pop RX)
//     01 status {TX_IDLE, OVR, PERR, FERR, RX_FULL, TX_FULL, rda, tbr}
//     10/11 baud divisor low/high byte
// Ports
//   clk      clock
//   rst      asynchronous reset, active low
//   bus      spart_fifo_if.slave: iocs/iorw/ioaddr in; rda/tbr/txd out; rxd in
//   databus  8-bit bidirectional data, driven only while iocs && iorw
module spart_fifo #(
    parameter int          DATA_W     = 8,
    parameter int          FIFO_DEPTH = 16,
    parameter int          PARITY     = 0,
    parameter int          OS         = 16,
    parameter logic [15:0] DB_RST     = 16'd325
) (
    input  logic         clk,
    input  logic         rst,
    spart_fifo_if.slave  bus,
    inout  wire  [7:0]   databus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(OS);
    localparam int BW = $clog2(DATA_W);
    localparam logic [CW-1:0] OS_LAST  = CW'(OS - 1);
    localparam logic [CW-1:0] OS_HALF  = CW'(OS / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    function automatic logic par_bit(input logic [DATA_W-1:0] d);
        return (PARITY == 2) ? ~^d : ^d;
    endfunction

    logic wr_en, rd_en, stat_rd;
    assign wr_en   = bus.iocs && !bus.iorw;
    assign rd_en   = bus.iocs &&  bus.iorw;
    assign stat_rd = rd_en && (bus.ioaddr == 2'b01);

    // Divisor and prescaler. The >= comparison keeps the tick period sane
    // when DB is lowered below the running count mid-frame.
    logic [15:0] db, ps_cnt;
    logic        tick;
    assign tick = (ps_cnt >= db);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db     <= DB_RST;
            ps_cnt <= '0;
        end else begin
            if (wr_en && bus.ioaddr == 2'b10) db[7:0]  <= databus;
            if (wr_en && bus.ioaddr == 2'b11) db[15:8] <= databus;
            if ((wr_en && bus.ioaddr[1]) || tick) ps_cnt <= '0;
            else                                  ps_cnt <= ps_cnt + 16'd1;
        end
    end

    // TX FIFO
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [AW:0]       tx_wp, tx_rp;
    logic              tx_empty, tx_full, tx_push, tx_pop;
    logic [DATA_W-1:0] tx_head;
    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign tx_push  = wr_en && (bus.ioaddr == 2'b00) && (!tx_full || tx_pop);
    assign tx_head  = tx_mem[tx_rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= databus[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
        end
    end

    // TX FSM. Entry into START is not aligned to a tick, so the start bit
    // may be up to one tick short. STOP chains straight into START when
    // more data is queued.
    state_t            tx_state, tx_next;
    logic [CW-1:0]     tx_cnt;
    logic [BW-1:0]     tx_bit;
    logic [DATA_W-1:0] tx_sh;
    logic              tx_par, tx_bit_end, txd_c;
    assign tx_bit_end = tick && (tx_cnt == OS_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tx_state <= S_IDLE;
        else      tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            S_IDLE:  if (!tx_empty) begin tx_pop = 1'b1; tx_next = S_START; end
            S_START: if (tx_bit_end) tx_next = S_DATA;
            S_DATA:  if (tx_bit_end && tx_bit == BIT_LAST) tx_next = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:   if (tx_bit_end) tx_next = S_STOP;
            S_STOP:  if (tx_bit_end) begin
                         if (!tx_empty) begin tx_pop = 1'b1; tx_next = S_START; end
                         else tx_next = S_IDLE;
                     end
            default: tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_cnt <= '0;
            tx_bit <= '0;
        end else if (tx_pop) begin
            tx_cnt <= '0;
            tx_bit <= '0;
        end else if (tick) begin
            tx_cnt <= (tx_cnt == OS_LAST) ? '0 : tx_cnt + 1'b1;
            if (tx_state == S_DATA && tx_cnt == OS_LAST) tx_bit <= tx_bit + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_pop) begin
            tx_sh  <= tx_head;
            tx_par <= par_bit(tx_head);
        end else if (tx_state == S_DATA && tx_bit_end) begin
            tx_sh  <= tx_sh >> 1;
        end
    end

    always_comb begin
        case (tx_state)
            S_START: txd_c = 1'b0;
            S_DATA:  txd_c = tx_sh[0];
            S_PAR:   txd_c = tx_par;
            default: txd_c = 1'b1;
        endcase
    end
    assign bus.txd = txd_c;

    // RX synchroniser; rx_s3 is the previous synchronised value for edge detection
    logic rx_s1, rx_s2, rx_s3, rx_fall;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) {rx_s1, rx_s2, rx_s3} <= 3'b111;
        else      {rx_s1, rx_s2, rx_s3} <= {bus.rxd, rx_s1, rx_s2};
    end
    assign rx_fall = rx_s3 && !rx_s2;

    // RX FIFO
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [AW:0]       rx_wp, rx_rp;
    logic              rx_empty, rx_full, rx_push, rx_pop;
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign rx_pop   = rd_en && (bus.ioaddr == 2'b00) && !rx_empty;

    // RX FSM. START samples at OS/2 ticks, later bits every OS ticks.
    state_t            rx_state, rx_next;
    logic [CW-1:0]     rx_cnt;
    logic [BW-1:0]     rx_bit;
    logic [DATA_W-1:0] rx_sh;
    logic              rx_parbit, rx_sample;
    logic              ferr_ev, perr_ev, ovr_ev;
    assign rx_sample = tick && (rx_cnt == ((rx_state == S_START) ? OS_HALF : OS_LAST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_state <= S_IDLE;
        else      rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        rx_push = 1'b0;
        ferr_ev = 1'b0;
        perr_ev = 1'b0;
        ovr_ev  = 1'b0;
        case (rx_state)
            S_IDLE:  if (rx_fall) rx_next = S_START;
            S_START: if (rx_sample) rx_next = rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (rx_sample && rx_bit == BIT_LAST) rx_next = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:   if (rx_sample) rx_next = S_STOP;
            S_STOP:  if (rx_sample) begin
                         rx_next = S_IDLE;
                         if (!rx_s2) ferr_ev = 1'b1;
                         else begin
                             perr_ev = (PARITY != 0) && (rx_parbit != par_bit(rx_sh));
                             if (rx_full && !rx_pop) ovr_ev  = 1'b1;
                             else                    rx_push = 1'b1;
                         end
                     end
            default: rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_cnt <= '0;
            rx_bit <= '0;
        end else if (rx_state == S_IDLE) begin
            rx_cnt <= '0;
            rx_bit <= '0;
        end else if (tick) begin
            rx_cnt <= rx_sample ? '0 : rx_cnt + 1'b1;
            if (rx_state == S_DATA && rx_sample) rx_bit <= rx_bit + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_state == S_DATA && rx_sample) rx_sh <= {rx_s2, rx_sh[DATA_W-1:1]};
        if (rx_state == S_PAR && rx_sample)  rx_parbit <= rx_s2;
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
    end

    // Sticky flags: an event in the clearing cycle wins
    logic ovr, perr, ferr;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wp <= '0;
            rx_rp <= '0;
            ovr   <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            ovr  <= ovr_ev  || (ovr  && !stat_rd);
            perr <= perr_ev || (perr && !stat_rd);
            ferr <= ferr_ev || (ferr && !stat_rd);
        end
    end

    // Bus read mux
    logic [7:0] rd_data;
    logic       tx_idle;
    assign tx_idle = tx_empty && (tx_state == S_IDLE);
    assign bus.rda = !rx_empty;
    assign bus.tbr = !tx_full;

    always_comb begin
        rd_data = '0;
        case (bus.ioaddr)
            2'b00:   if (!rx_empty) rd_data[DATA_W-1:0] = rx_mem[rx_rp[AW-1:0]];
            2'b01:   rd_data = {tx_idle, ovr, perr, ferr, rx_full, tx_full, !rx_empty, !tx_full};
            2'b10:   rd_data = db[7:0];
            default: rd_data = db[15:8];
        endcase
    end
    assign databus = rd_en ? rd_data : 8'hzz;
endmodule

// File: tb/tb_spart_fifo.sv
// tb_spart_fifo
//   Directed bench for spart_fifo (DATA_W=8, FIFO_DEPTH=4, PARITY=even, OS=16).
//   Bus reads push their expected value into a queue. A monitor checks every
//   read cycle the DUT serves against the head of that queue.
module tb_spart_fifo;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spart_fifo_if bus ();
    tri1 [7:0] databus;     // floats high when nobody drives it
    logic [7:0] wdata;
    logic       loop, rx_drv;

    assign databus = (bus.iocs && !bus.iorw) ? wdata : 8'hzz;
    assign bus.rxd = loop ? bus.txd : rx_drv;

    spart_fifo #(
        .DATA_W(8), .FIFO_DEPTH(DEPTH), .PARITY(1), .OS(16), .DB_RST(16'd325)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .databus(databus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor for bus reads
    always @(negedge clk) begin
        exp_t e;
        if (bus.iocs && bus.iorw) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read: got %0h expected no read", databus);
            end else begin
                e = exp_q.pop_front();
                check(e.name, {8'h00, databus}, {8'h00, e.val});
            end
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = a; wdata = d;
        @(posedge clk); #1;
        bus.iocs = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [7:0] e, input string name);
        @(posedge clk); #1;
        bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = a;
        exp_q.push_back('{name, e});
        @(posedge clk); #1;
        bus.iocs = 1'b0; bus.iorw = 1'b0;
    endtask

    // One frame on rxd at DB=0 (16 clk per bit), even parity
    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [10:0] f;
        f = {stop, ^d, d, 1'b0};
        @(posedge clk); #1;
        for (int i = 0; i < 11; i++) begin
            rx_drv = f[i];
            repeat (16) @(posedge clk);
            #1;
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] txe;
        int         n;
        int         len;

        bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'b00;
        wdata = 8'h00; loop = 1'b0; rx_drv = 1'b1;

        // Reset and idle state
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("idle_databus", {8'h00, databus}, 16'h00ff);
        check("reset_txd", {15'd0, bus.txd}, 16'd1);
        check("reset_rda", {15'd0, bus.rda}, 16'd0);
        check("reset_tbr", {15'd0, bus.tbr}, 16'd1);
        bus_read(2'b01, 8'h81, "status_reset");
        bus_read(2'b10, 8'h45, "db_lo_reset");
        bus_read(2'b11, 8'h01, "db_hi_reset");
        bus_read(2'b00, 8'h00, "empty_rx_read");

        // Serial waveform of 0xA5 at DB=3: 64 clk per bit, even parity bit 0
        bus_write(2'b10, 8'd3);
        bus_write(2'b11, 8'd0);
        bus_write(2'b00, 8'hA5);
        n = 0;
        while (bus.txd && n < 50) begin @(negedge clk); n++; end
        check("tx_start_seen", {15'd0, bus.txd}, 16'd0);
        len = 0;
        while (!bus.txd && len < 100) begin @(negedge clk); len++; end
        checks++;
        if (len < 60 || len > 68) begin
            failures++;
            $display("FAIL tx_start_len: got %0d clk expected 60..68", len);
        end
        repeat (31) @(negedge clk);
        txe = {1'b1, 1'b0, 8'hA5};
        for (int i = 0; i < 10; i++) begin
            check($sformatf("tx_bit%0d", i), {15'd0, bus.txd}, {15'd0, txe[i]});
            repeat (64) @(negedge clk);
        end
        bus_read(2'b01, 8'h81, "status_tx_done");

        // Loopback at DB=0
        bus_write(2'b10, 8'd0);
        loop = 1'b1;
        bus_write(2'b00, 8'h3C);
        bus_write(2'b00, 8'h00);
        bus_write(2'b00, 8'hFF);
        repeat (700) @(posedge clk);
        bus_read(2'b00, 8'h3C, "loop_byte0");
        bus_read(2'b00, 8'h00, "loop_byte1");
        bus_read(2'b00, 8'hFF, "loop_byte2");
        @(negedge clk);
        check("loop_rda_drop", {15'd0, bus.rda}, 16'd0);
        bus_read(2'b01, 8'h81, "status_loop");
        loop = 1'b0;

        // RX overrun: 2*DEPTH frames, no reads
        for (int i = 0; i < 2 * DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("ovr_rda", {15'd0, bus.rda}, 16'd1);
        bus_read(2'b01, 8'hCB, "status_overrun");
        for (int i = 0; i < DEPTH; i++)
            bus_read(2'b00, 8'h10 + 8'(i), $sformatf("ovr_byte%0d", i));
        bus_read(2'b01, 8'h81, "status_after_drain");

        // Framing error
        send_frame(8'h55, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("ferr_rda", {15'd0, bus.rda}, 16'd0);
        bus_read(2'b01, 8'h91, "status_ferr");
        bus_read(2'b01, 8'h81, "status_ferr_cleared");

        // Quarter-bit glitch on rxd
        @(posedge clk); #1 rx_drv = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx_drv = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("glitch_rda", {15'd0, bus.rda}, 16'd0);
        bus_read(2'b01, 8'h81, "status_glitch");

        // Reset mid-frame
        bus_write(2'b10, 8'd3);
        bus_write(2'b00, 8'h00);
        repeat (150) @(posedge clk);
        @(negedge clk);
        check("tx_low_before_rst", {15'd0, bus.txd}, 16'd0);
        #2 rst = 1'b0;
        #1;
        check("rst_txd", {15'd0, bus.txd}, 16'd1);
        check("rst_tbr", {15'd0, bus.tbr}, 16'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        bus_read(2'b01, 8'h81, "status_after_rst");
        bus_read(2'b10, 8'h45, "db_lo_after_rst");
        bus_read(2'b11, 8'h01, "db_hi_after_rst");

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
